// File: rtl/serv_rf_ram_bridge.sv
// Bridge between SERV's bit-serial register-file port and a WIDTH-bit synchronous RAM.
// Prefetches and deserialises two read operands; packs two serial write streams into RAM words.
module serv_rf_ram_bridge #(
    parameter int WIDTH    = 8,
    parameter int CSR_REGS = 4,
    localparam int CW = $clog2(32 / WIDTH),
    localparam int PW = $clog2(WIDTH),
    localparam int RW = (CSR_REGS != 0) ? 6 : 5,
    localparam int AW = RW + CW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rreq,
    input  logic [RW-1:0] i_rreg0,
    input  logic [RW-1:0] i_rreg1,
    output logic          o_ready,
    input  logic          i_cnt_en,
    output logic          o_rdata0,
    output logic          o_rdata1,
    input  logic [RW-1:0] i_wreg0,
    input  logic [RW-1:0] i_wreg1,
    input  logic          i_wen0,
    input  logic          i_wen1,
    input  logic          i_wdata0,
    input  logic          i_wdata1,
    output logic [AW-1:0] o_waddr,
    output logic [WIDTH-1:0] o_wdata,
    output logic          o_wen,
    output logic [AW-1:0] o_raddr,
    output logic          o_ren,
    input  logic [WIDTH-1:0] i_rdata
);
    localparam int CWI = (CW > 0) ? CW : 1;
    localparam logic [CWI:0]  LAST_CHUNK = (CWI + 1)'(32 / WIDTH - 1);
    localparam logic [PW-1:0] POS_PF0    = PW'(WIDTH - 3);
    localparam logic [PW-1:0] POS_PF1    = PW'(WIDTH - 2);
    localparam logic [PW-1:0] POS_LAST   = PW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH1, S_PRIME, S_STREAM} state_t;

    state_t            r_state, w_state_nx;
    logic [4:0]        r_cnt;
    logic [RW-1:0]     r_rreg0, r_rreg1, r_wreg0, r_wreg1;
    logic [WIDTH-1:0]  r_rsh0, r_rsh1, r_rhold0, r_rhold1;
    logic [WIDTH-1:0]  r_wsh0, r_wsh1, r_whold0, r_whold1;
    logic              r_cap0, r_cap1;
    logic              r_wl0, r_wl1, r_wslot0, r_wslot1;
    logic [CWI-1:0]    r_wchunk;

    logic [CWI-1:0]    w_chunk, w_nchunk;
    logic [PW-1:0]     w_pos;
    logic              w_step, w_more, w_pf0, w_pf1, w_bnd, w_start;
    logic              w_wen0, w_wen1;

    // RAM word address {reg, chunk}; chunk collapses to nothing when WIDTH is 32
    function automatic logic [AW-1:0] ram_addr(input logic [RW-1:0] rreg, input logic [CWI-1:0] chunk);
        ram_addr = (AW'(rreg) << CW) | AW'(chunk);
    endfunction

    assign w_chunk  = CWI'(r_cnt >> PW);
    assign w_nchunk = w_chunk + CWI'(1);
    assign w_pos    = r_cnt[PW-1:0];
    assign w_step   = (r_state == S_STREAM) && i_cnt_en;
    assign w_more   = ({1'b0, w_chunk} < LAST_CHUNK);
    assign w_pf0    = w_step && w_more && (w_pos == POS_PF0);
    assign w_pf1    = w_step && w_more && (w_pos == POS_PF1);
    assign w_bnd    = w_step && (w_pos == POS_LAST);
    assign w_start  = (r_state == S_IDLE) && i_rreq && i_rst_n;
    assign w_wen0   = r_wslot0 && r_wl0;
    assign w_wen1   = r_wslot1 && r_wl1;

    assign o_rdata0 = r_rsh0[0];
    assign o_rdata1 = r_rsh1[0];

    // Next state and RAM read port
    always_comb begin
        w_state_nx = r_state;
        o_ren      = 1'b0;
        o_raddr    = '0;
        o_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx = S_FETCH1;
                    o_ren      = 1'b1;
                    o_raddr    = ram_addr(i_rreg0, '0);
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_FETCH1: begin
                o_ren      = 1'b1;
                o_raddr    = ram_addr(r_rreg1, '0);
                w_state_nx = S_PRIME;
            end
            S_PRIME: begin
                o_ready    = 1'b1;
                w_state_nx = S_STREAM;
            end
            S_STREAM: begin
                if (w_pf0) begin
                    o_ren   = 1'b1;
                    o_raddr = ram_addr(r_rreg0, w_nchunk);
                end else if (w_pf1) begin
                    o_ren   = 1'b1;
                    o_raddr = ram_addr(r_rreg1, w_nchunk);
                end else begin
                    o_ren   = 1'b0;
                end
                if (w_step && (r_cnt == 5'd31)) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_STREAM;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // RAM write port: slot 0 drains port 0, the following cycle drains port 1
    always_comb begin
        o_wen   = w_wen0 || w_wen1;
        o_waddr = '0;
        o_wdata = '0;
        if (w_wen0) begin
            o_waddr = ram_addr(r_wreg0, r_wchunk);
            o_wdata = r_whold0;
        end else if (w_wen1) begin
            o_waddr = ram_addr(r_wreg1, r_wchunk);
            o_wdata = r_whold1;
        end else begin
            o_waddr = '0;
            o_wdata = '0;
        end
    end

    // FSM state, bit counter and operand addresses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_rreg0 <= '0;
            r_rreg1 <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_start) begin
                r_cnt   <= 5'd0;
                r_rreg0 <= i_rreg0;
                r_rreg1 <= i_rreg1;
            end else if (w_step) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Read side: prefetch capture into hold registers, serial shift-out
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cap0   <= 1'b0;
            r_cap1   <= 1'b0;
            r_rhold0 <= '0;
            r_rhold1 <= '0;
            r_rsh0   <= '0;
            r_rsh1   <= '0;
        end else begin
            r_cap0 <= w_pf0;
            r_cap1 <= w_pf1;
            if (r_cap0) r_rhold0 <= i_rdata;
            if (r_cap1) r_rhold1 <= i_rdata;
            if (r_state == S_FETCH1) begin
                r_rsh0 <= i_rdata;
            end else if (w_bnd) begin
                r_rsh0 <= r_rhold0;
            end else if (w_step) begin
                r_rsh0 <= {1'b0, r_rsh0[WIDTH-1:1]};
            end
            // operand 1 may arrive in the very cycle it is needed: bypass the hold register
            if (r_state == S_PRIME) begin
                r_rsh1 <= i_rdata;
            end else if (w_bnd) begin
                r_rsh1 <= r_cap1 ? i_rdata : r_rhold1;
            end else if (w_step) begin
                r_rsh1 <= {1'b0, r_rsh1[WIDTH-1:1]};
            end
        end
    end

    // Write side: serial shift-in, word packing and two-slot drain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wsh0   <= '0;
            r_wsh1   <= '0;
            r_whold0 <= '0;
            r_whold1 <= '0;
            r_wl0    <= 1'b0;
            r_wl1    <= 1'b0;
            r_wchunk <= '0;
            r_wreg0  <= '0;
            r_wreg1  <= '0;
            r_wslot0 <= 1'b0;
            r_wslot1 <= 1'b0;
        end else begin
            if (w_step) begin
                r_wsh0 <= {i_wdata0, r_wsh0[WIDTH-1:1]};
                r_wsh1 <= {i_wdata1, r_wsh1[WIDTH-1:1]};
            end
            if (w_bnd) begin
                r_whold0 <= {i_wdata0, r_wsh0[WIDTH-1:1]};
                r_whold1 <= {i_wdata1, r_wsh1[WIDTH-1:1]};
                r_wl0    <= i_wen0;
                r_wl1    <= i_wen1;
                r_wchunk <= w_chunk;
                r_wreg0  <= i_wreg0;
                r_wreg1  <= i_wreg1;
            end
            r_wslot0 <= w_bnd;
            r_wslot1 <= r_wslot0;
        end
    end

endmodule

// File: tb/tb_serv_rf_ram_bridge.sv
// Directed bench for serv_rf_ram_bridge: default build (WIDTH=8, CSR_REGS=4) against a RAM model,
// plus WIDTH=4 and WIDTH=32 builds (CSR_REGS=0) sharing the read stimulus.
module tb_serv_rf_ram_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rreq, cnt_en, wen0, wen1, wd0, wd1;
    logic [5:0] rreg0, rreg1, wreg0, wreg1;

    logic       ready, rd0, rd1, wen, ren;
    logic [7:0] waddr, wdata, raddr, rdata;

    logic       a_ready, a_rd0, a_rd1, a_wen, a_ren;
    logic [7:0] a_waddr, a_raddr;
    logic [3:0] a_wdata, a_rdata;

    logic        b_ready, b_rd0, b_rd1, b_wen, b_ren;
    logic [4:0]  b_waddr, b_raddr;
    logic [31:0] b_wdata, b_rdata;

    serv_rf_ram_bridge dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq), .i_rreg0(rreg0), .i_rreg1(rreg1),
        .o_ready(ready), .i_cnt_en(cnt_en), .o_rdata0(rd0), .o_rdata1(rd1),
        .i_wreg0(wreg0), .i_wreg1(wreg1), .i_wen0(wen0), .i_wen1(wen1),
        .i_wdata0(wd0), .i_wdata1(wd1), .o_waddr(waddr), .o_wdata(wdata), .o_wen(wen),
        .o_raddr(raddr), .o_ren(ren), .i_rdata(rdata));

    serv_rf_ram_bridge #(.WIDTH(4), .CSR_REGS(0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq), .i_rreg0(rreg0[4:0]), .i_rreg1(rreg1[4:0]),
        .o_ready(a_ready), .i_cnt_en(cnt_en), .o_rdata0(a_rd0), .o_rdata1(a_rd1),
        .i_wreg0(5'd0), .i_wreg1(5'd0), .i_wen0(1'b0), .i_wen1(1'b0),
        .i_wdata0(1'b0), .i_wdata1(1'b0), .o_waddr(a_waddr), .o_wdata(a_wdata), .o_wen(a_wen),
        .o_raddr(a_raddr), .o_ren(a_ren), .i_rdata(a_rdata));

    serv_rf_ram_bridge #(.WIDTH(32), .CSR_REGS(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq), .i_rreg0(rreg0[4:0]), .i_rreg1(rreg1[4:0]),
        .o_ready(b_ready), .i_cnt_en(cnt_en), .o_rdata0(b_rd0), .o_rdata1(b_rd1),
        .i_wreg0(5'd0), .i_wreg1(5'd0), .i_wen0(1'b0), .i_wen1(1'b0),
        .i_wdata0(1'b0), .i_wdata1(1'b0), .o_waddr(b_waddr), .o_wdata(b_wdata), .o_wen(b_wen),
        .o_raddr(b_raddr), .o_ren(b_ren), .i_rdata(b_rdata));

    // RAM models; the main one has a bench-side preload port
    logic [7:0]  mem [0:255];
    logic [3:0]  ma  [0:255];
    logic [31:0] mb  [0:31];
    logic        bd_we;
    logic [7:0]  bd_a, bd_d;

    always @(posedge clk) begin
        if (bd_we) mem[bd_a] <= bd_d;
        else if (wen) mem[waddr] <= wdata;
        if (ren) rdata <= mem[raddr];
        if (a_ren) a_rdata <= ma[a_raddr];
        if (b_ren) b_rdata <= mb[b_raddr];
    end

    // Traffic log of the main RAM ports
    int           rcnt = 0, wcnt = 0;
    logic [63:0]  rlog = '0;
    logic [127:0] wlog = '0;
    always @(posedge clk) begin
        if (ren) begin
            rcnt <= rcnt + 1;
            rlog <= {rlog[55:0], raddr};
        end
        if (wen) begin
            wcnt <= wcnt + 1;
            wlog <= {wlog[111:0], waddr, wdata};
        end
    end

    int n_total = 0, n_bad = 0;
    logic [31:0] obs0, obs1, a0, a1, b0, b1;
    logic [31:0] x5, x6;
    int r_snap, w_snap;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input logic [5:0] r0, input logic [5:0] r1, input bit stall,
                              input logic [31:0] w0, input logic [31:0] w1);
        rreg0 = r0; rreg1 = r1; rreq = 1'b1;
        @(negedge clk);
        chk("ren_t", {ren, raddr}, {1'b1, r0, 2'b00});
        step();
        rreq = 1'b0;
        @(negedge clk);
        chk("ren_t1", {ren, raddr, ready}, {1'b1, r1, 2'b00, 1'b0});
        step();
        @(negedge clk);
        chk("ready_t2", {ready, ren}, 2'b10);
        step();
        for (int b = 0; b < 32; b++) begin
            if (stall && ((b % 8) >= 6)) begin
                cnt_en = 1'b0;
                step();
            end
            cnt_en = 1'b1; wd0 = w0[b]; wd1 = w1[b];
            @(negedge clk);
            obs0[b] = rd0;   obs1[b] = rd1;
            a0[b]   = a_rd0; a1[b]   = a_rd1;
            b0[b]   = b_rd0; b1[b]   = b_rd1;
            step();
        end
        cnt_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rreq = 1'b0; cnt_en = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
        wd0 = 1'b0; wd1 = 1'b0; rreg0 = '0; rreg1 = '0; wreg0 = '0; wreg1 = '0;
        bd_we = 1'b0; bd_a = '0; bd_d = '0;
        x5 = 32'hDEADBEEF; x6 = 32'h12345678;
        for (int i = 0; i < 256; i++) ma[i] = 4'h0;
        for (int i = 0; i < 32; i++) mb[i] = 32'h0;
        for (int c = 0; c < 8; c++) begin
            ma[40 + c] = x5[4*c +: 4];
            ma[48 + c] = x6[4*c +: 4];
        end
        mb[5] = x5; mb[6] = x6;

        // reset with random inputs: every output stays 0
        for (int i = 0; i < 3; i++) begin
            step();
            rreq = 1'($urandom); cnt_en = 1'($urandom); wen0 = 1'($urandom); wen1 = 1'($urandom);
            wd0 = 1'($urandom); wd1 = 1'($urandom); rreg0 = 6'($urandom); rreg1 = 6'($urandom);
            wreg0 = 6'($urandom); wreg1 = 6'($urandom);
            @(negedge clk);
            chk("reset_outs", {ready, rd0, rd1, wen, ren, waddr, wdata, raddr}, '0);
            chk("reset_outs_ab", {a_ready, a_wen, a_ren, a_raddr, b_ready, b_wen, b_ren, b_raddr}, '0);
        end
        step();
        rreq = 1'b0; cnt_en = 1'b0; wen0 = 1'b0; wen1 = 1'b0; wd0 = 1'b0; wd1 = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bd_we = 1'b1; bd_a = {6'd5, 2'(c)}; bd_d = x5[8*c +: 8];
            step();
            bd_a = {6'd6, 2'(c)}; bd_d = x6[8*c +: 8];
            step();
        end
        bd_we = 1'b0;
        step();

        // plain read stream
        r_snap = rcnt; w_snap = wcnt;
        run_stream(6'd5, 6'd6, 1'b0, 32'h0, 32'h0);
        chk("rd0_w8", obs0, x5);
        chk("rd1_w8", obs1, x6);
        chk("rd_count", 32'(rcnt - r_snap), 32'd8);
        chk("rd_addrs", rlog, 64'h1418_1519_161A_171B);
        chk("no_writes", 32'(wcnt - w_snap), 32'd0);
        chk("rd_w4", {a0, a1}, {x5, x6});
        chk("rd_w32", {b0, b1}, {x5, x6});
        step();

        // stalls at pos 6 and 7 of every chunk
        r_snap = rcnt;
        run_stream(6'd5, 6'd6, 1'b1, 32'h0, 32'h0);
        chk("stall_rd", {obs0, obs1}, {x5, x6});
        chk("stall_rd_count", 32'(rcnt - r_snap), 32'd8);
        chk("stall_rd_addrs", rlog, 64'h1418_1519_161A_171B);
        chk("stall_w4_w32", {a0, a1, b0, b1}, {x5, x6, x5, x6});
        step();

        // write both ports; last chunk drains after the FSM is back in IDLE
        wreg0 = 6'd7; wreg1 = 6'd32; wen0 = 1'b1; wen1 = 1'b1;
        w_snap = wcnt;
        run_stream(6'd5, 6'd6, 1'b0, 32'hCAFEF00D, 32'h0F0F0F0F);
        @(negedge clk);
        chk("drain_slot0", {wen, waddr, wdata, ready, ren}, {1'b1, 8'd31, 8'hCA, 2'b00});
        step();
        @(negedge clk);
        chk("drain_slot1", {wen, waddr, wdata}, {1'b1, 8'd131, 8'h0F});
        step();
        chk("wr_count", 32'(wcnt - w_snap), 32'd8);
        chk("wr_log", wlog, 128'h1C0D_800F_1DF0_810F_1EFE_820F_1FCA_830F);
        chk("wr_mem", {mem[28], mem[29], mem[30], mem[31], mem[128]}, 40'h0DF0FECA0F);

        // port 0 disabled: only the second slot of each pair writes
        wen0 = 1'b0; wen1 = 1'b1; wreg0 = 6'd3; wreg1 = 6'd9;
        w_snap = wcnt;
        run_stream(6'd5, 6'd6, 1'b0, 32'hFFFFFFFF, 32'hA5A53C3C);
        @(negedge clk);
        chk("dis_slot0", wen, 1'b0);
        step();
        @(negedge clk);
        chk("dis_slot1", {wen, waddr, wdata}, {1'b1, 8'd39, 8'hA5});
        step();
        chk("dis_count", 32'(wcnt - w_snap), 32'd4);
        chk("dis_log", wlog[63:0], 64'h243C_253C_26A5_27A5);
        wen1 = 1'b0;

        // mid-stream reset at cnt=13
        wen0 = 1'b1; wreg0 = 6'd7;
        rreg0 = 6'd5; rreg1 = 6'd6; rreq = 1'b1;
        step();
        rreq = 1'b0;
        step();
        step();
        cnt_en = 1'b1;
        for (int b = 0; b < 13; b++) step();
        rst_n = 1'b0;
        r_snap = rcnt; w_snap = wcnt;
        @(negedge clk);
        chk("midrst_outs", {ready, rd0, rd1, wen, ren, waddr, wdata, raddr}, '0);
        step();
        step();
        rst_n = 1'b1;
        for (int b = 0; b < 10; b++) step();
        cnt_en = 1'b0; wen0 = 1'b0;
        chk("midrst_quiet", {32'(rcnt - r_snap), 32'(wcnt - w_snap)}, 64'd0);
        step();
        r_snap = rcnt;
        run_stream(6'd5, 6'd6, 1'b0, 32'h0, 32'h0);
        chk("post_rst_rd", {obs0, obs1}, {x5, x6});
        chk("post_rst_count", 32'(rcnt - r_snap), 32'd8);
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
